calc_engine: RTL and testbench
==============================

Name: calc_engine

Overview:
- Calculator control and arithmetic stage. Sits directly downstream of the 4x4 matrix keyboard scanner and consumes its 16-bit one-cycle key_pulse vector.
- Assembles decimal operands from digit keys and applies + - * / with left-to-right chaining.
- Presents a signed-magnitude binary value, error flag and busy flag to the display/BCD stage.

Parameters:
- MAX_DIGITS, 8: maximum decimal digits per operand and per result magnitude.
- DATA_W, 27: magnitude width in bits. Requires 2^DATA_W > 10^MAX_DIGITS - 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_pulse  in  16  one-cycle key strobes from keyboard. Bits 0-9 = digits 0-9, 10 = '+', 11 = '-', 12 = '*', 13 = '/', 14 = '=', 15 = 'C'.
- disp_val  out  DATA_W  magnitude to display.
- disp_neg  out  1  sign of disp_val (1 = negative).
- err  out  1  error state (overflow or divide by zero).
- busy  out  1  arithmetic in progress; keys are ignored while high.

Behaviour:
- Reset: all registers cleared. disp_val=0, disp_neg=0, err=0, busy=0, state=ENTER_A. A=B=0, op=none, digit count=0.
- Key acceptance:
  - A key is accepted only when exactly one bit of key_pulse is set.
  - Zero or multiple set bits in one cycle: no effect.
  - Keys arriving while busy=1 are dropped, except 'C', which is always honoured.
- 'C' in any state, including mid-division: same cycle returns to reset values (busy cleared, divider aborted).
- Digit entry: entry = entry*10 + d, signed value positive.
  - Digit count is held per operand; digits beyond MAX_DIGITS are ignored.
  - Leading zeros do not increment the count while entry=0.
- States:
  - ENTER_A: digit -> update A, disp shows A. Operator -> store op, go OP_WAIT. '=' -> no-op.
  - OP_WAIT: disp shows A. Operator -> replace op. Digit -> B=d, count=1, go ENTER_B. '=' -> no-op.
  - ENTER_B: digit -> update B, disp shows B.
    - Operator -> compute A op B; on success A=result, store new op, go OP_WAIT.
    - '=' -> compute, go RESULT.
  - CALC: busy=1. On completion, go to the pending target (OP_WAIT or RESULT) or to ERROR.
  - RESULT: disp shows result (held in A).
    - Digit -> A=d, count=1, go ENTER_A.
    - Operator -> keep A as left operand, store op, go OP_WAIT.
    - '=' -> no-op.
  - ERROR: err=1, disp_val=0, disp_neg=0. Only 'C' leaves, to ENTER_A.
- Arithmetic:
  - Operands are signed magnitude internally.
  - Add/sub: single-cycle signed.
  - Mul: single-cycle 2*DATA_W-bit product.
  - Div: restoring, one quotient bit per cycle, DATA_W iterations on magnitudes. Quotient is truncated toward zero; sign = XOR of operand signs; remainder is discarded.
  - A zero result is always reported with disp_neg=0.
- Latency: key strobe at cycle N, busy high from N+1.
  - Add/sub/mul: result visible and busy low at N+2.
  - Div: result visible and busy low at N+DATA_W+2.
- Boundaries:
  - A result magnitude > 10^MAX_DIGITS - 1 -> ERROR. Detection uses full-width product/sum before truncation.
  - Divisor 0 -> ERROR, detected in the first CALC cycle (busy low at N+2).
  - Subtraction crossing zero produces the correct sign.
  - Chaining evaluates strictly left to right, with no precedence.
- Outputs are registered. disp_* update only on state/entry changes.

Test Plan:
- Keys 1,2,+,3,4,= (one pulse each, 5 idle cycles apart) -> disp_val=46, disp_neg=0, busy high exactly 1 cycle after '='.
- Keys 7,-,9,= -> disp_val=2, disp_neg=1. Then '+',5,= -> disp_val=3, disp_neg=0.
- Keys 1,0,0,/,7,= -> busy high for DATA_W+1 cycles (28 at default), then disp_val=14. Keys -,1,0,0,/,7 (i.e. -100/7 after a prior 0-100) -> -14, truncated toward zero.
- Chain 2,+,3,*,4,= -> after '*' disp_val=5, final disp_val=20. Operator replacement 2,+,-,1,= -> 1.
- Error cases:
  - 5,/,0,= -> err=1, disp_val=0; digit keys are then ignored; 'C' -> err=0, all zeros.
  - 9 x8, +, 1, = -> err=1 (overflow).
  - Entering 9 digits 1..9 -> disp_val=12345678; 9th digit ignored.
- Robustness:
  - key_pulse=16'h0003 (two bits set) -> no state change.
  - A digit pulse during a division busy window is ignored.
  - 'C' mid-division -> busy=0 and disp_val=0 next cycle.
  - rst_n low mid-entry -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/calc_engine.sv
// Calculator control and arithmetic stage: builds decimal operands from keypad strobes and
// evaluates + - * / strictly left to right, presenting a signed-magnitude result.
module calc_engine #(
   parameter int MAX_DIGITS = 8,
   parameter int DATA_W     = 27
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       key_pulse,
   output logic [DATA_W-1:0] disp_val,
   output logic              disp_neg,
   output logic              err,
   output logic              busy
);

   typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, CALC, RESULT, ERROR} state_t;
   typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = DATA_W + 2;
   localparam int DIG_W  = $clog2(MAX_DIGITS + 1);
   localparam int CNT_W  = $clog2(DATA_W + 1);

   function automatic logic [PROD_W-1:0] max_mag();
      logic [PROD_W-1:0] v;
      v = PROD_W'(1);
      for (int i = 0; i < MAX_DIGITS; i++) v = v * PROD_W'(10);
      return v - PROD_W'(1);
   endfunction

   localparam logic [PROD_W-1:0] MAX_VAL = max_mag();

   state_t            state, state_n;
   op_t               op, op_n, calc_op, calc_op_n;
   logic              to_result, to_result_n;
   logic [DATA_W-1:0] a_mag, a_mag_n, b_mag, b_mag_n;
   logic              a_neg, a_neg_n;
   logic [DIG_W-1:0]  dig_cnt, dig_cnt_n;
   logic [CNT_W-1:0]  div_cnt, div_cnt_n;
   logic [DATA_W-1:0] div_rem, div_rem_n, div_q, div_q_n;
   logic [DATA_W-1:0] disp_val_n;
   logic              disp_neg_n;

   // Key decode: only a single set bit counts as a key press.
   logic       key_ok, is_digit, is_op, is_eq, is_clr;
   logic [3:0] key_idx;
   op_t        key_op;

   always_comb begin
      key_idx = '0;
      for (int i = 0; i < 16; i++)
         if (key_pulse[i]) key_idx = 4'(i);
   end

   assign key_ok   = $onehot(key_pulse);
   assign is_digit = key_ok && (key_idx <= 4'd9);
   assign is_op    = key_ok && (key_idx >= 4'd10) && (key_idx <= 4'd13);
   assign is_eq    = key_ok && (key_idx == 4'd14);
   assign is_clr   = key_ok && (key_idx == 4'd15);

   always_comb begin
      case (key_idx)
         4'd10:   key_op = OP_ADD;
         4'd11:   key_op = OP_SUB;
         4'd12:   key_op = OP_MUL;
         default: key_op = OP_DIV;
      endcase
   end

   // Digit accumulation into whichever operand is being entered.
   logic [DATA_W-1:0] digit, entry, entry_n;
   logic [DIG_W-1:0]  entry_cnt_n;

   assign digit = DATA_W'(key_idx);
   assign entry = (state == ENTER_B) ? b_mag : a_mag;

   always_comb begin
      entry_n     = entry;
      entry_cnt_n = dig_cnt;
      if (!(entry == '0 && digit == '0) && dig_cnt < DIG_W'(MAX_DIGITS)) begin
         entry_n     = entry * DATA_W'(10) + digit;
         entry_cnt_n = dig_cnt + 1'b1;
      end
   end

   // Datapath: signed add/sub, full-width product and one restoring-division step.
   logic signed [SUM_W-1:0] a_s, b_s, sum_s;
   logic [SUM_W-1:0]        sum_mag;
   logic [PROD_W-1:0]       prod;
   logic [DATA_W:0]         rem_shift;
   logic                    rem_ge;
   logic [DATA_W-1:0]       quot, res_mag;
   logic                    res_neg, res_ovf;
   state_t                  target;

   assign a_s       = a_neg ? -$signed({2'b00, a_mag}) : $signed({2'b00, a_mag});
   assign b_s       = $signed({2'b00, b_mag});
   assign sum_s     = (calc_op == OP_SUB) ? a_s - b_s : a_s + b_s;
   assign sum_mag   = sum_s[SUM_W-1] ? $unsigned(-sum_s) : $unsigned(sum_s);
   assign prod      = {{DATA_W{1'b0}}, a_mag} * {{DATA_W{1'b0}}, b_mag};
   assign rem_shift = {div_rem, div_q[DATA_W-1]};
   assign rem_ge    = rem_shift >= {1'b0, b_mag};
   assign quot      = {div_q[DATA_W-2:0], rem_ge};
   assign target    = to_result ? RESULT : OP_WAIT;

   always_comb begin
      if (calc_op == OP_MUL) begin
         res_ovf = prod > MAX_VAL;
         res_mag = prod[DATA_W-1:0];
         res_neg = a_neg && (prod != '0);
      end else begin
         res_ovf = {{(PROD_W-SUM_W){1'b0}}, sum_mag} > MAX_VAL;
         res_mag = sum_mag[DATA_W-1:0];
         res_neg = sum_s[SUM_W-1];
      end
   end

   always_comb begin
      // NOTE: every next-value defaults to the current register so no path infers a latch.
      state_n = state;  op_n = op;  calc_op_n = calc_op;  to_result_n = to_result;
      a_mag_n = a_mag;  a_neg_n = a_neg;  b_mag_n = b_mag;  dig_cnt_n = dig_cnt;
      div_cnt_n = div_cnt;  div_rem_n = div_rem;  div_q_n = div_q;
      if (is_clr) begin
         state_n = ENTER_A;  op_n = OP_NONE;  calc_op_n = OP_NONE;  to_result_n = 1'b0;
         a_mag_n = '0;  a_neg_n = 1'b0;  b_mag_n = '0;  dig_cnt_n = '0;
         div_cnt_n = '0;  div_rem_n = '0;  div_q_n = '0;
      end else begin
         case (state)
            ENTER_A: begin
               if (is_digit) begin
                  a_mag_n = entry_n;  a_neg_n = 1'b0;  dig_cnt_n = entry_cnt_n;
               end else if (is_op) begin
                  op_n = key_op;  state_n = OP_WAIT;
               end
            end
            OP_WAIT: begin
               if (is_digit) begin
                  b_mag_n = digit;  dig_cnt_n = DIG_W'(1);  state_n = ENTER_B;
               end else if (is_op) begin
                  op_n = key_op;
               end
            end
            ENTER_B: begin
               if (is_digit) begin
                  b_mag_n = entry_n;  dig_cnt_n = entry_cnt_n;
               end else if (is_op || is_eq) begin
                  calc_op_n = op;  to_result_n = is_eq;  div_cnt_n = '0;  state_n = CALC;
                  if (is_op) op_n = key_op;
               end
            end
            CALC: begin
               if (calc_op == OP_DIV) begin
                  // Step 0 screens the divisor and loads the dividend; steps 1..DATA_W iterate.
                  if (div_cnt == '0) begin
                     if (b_mag == '0) state_n = ERROR;
                     else begin
                        div_rem_n = '0;  div_q_n = a_mag;  div_cnt_n = CNT_W'(1);
                     end
                  end else begin
                     div_rem_n = rem_ge ? DATA_W'(rem_shift - {1'b0, b_mag}) : DATA_W'(rem_shift);
                     div_q_n   = quot;
                     div_cnt_n = div_cnt + 1'b1;
                     if (div_cnt == CNT_W'(DATA_W)) begin
                        a_mag_n = quot;  a_neg_n = a_neg && (quot != '0);  state_n = target;
                     end
                  end
               end else if (res_ovf) begin
                  state_n = ERROR;
               end else begin
                  a_mag_n = res_mag;  a_neg_n = res_neg;  state_n = target;
               end
            end
            RESULT: begin
               if (is_digit) begin
                  a_mag_n = digit;  a_neg_n = 1'b0;  dig_cnt_n = DIG_W'(1);  state_n = ENTER_A;
               end else if (is_op) begin
                  op_n = key_op;  state_n = OP_WAIT;
               end
            end
            default: ;
         endcase
      end
   end

   // Display follows the state being entered; it holds its last value while busy.
   always_comb begin
      disp_val_n = disp_val;
      disp_neg_n = disp_neg;
      case (state_n)
         ENTER_B: begin disp_val_n = b_mag_n;  disp_neg_n = 1'b0; end
         CALC:    ;
         ERROR:   begin disp_val_n = '0;  disp_neg_n = 1'b0; end
         default: begin disp_val_n = a_mag_n;  disp_neg_n = a_neg_n; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ENTER_A;  op <= OP_NONE;  calc_op <= OP_NONE;  to_result <= 1'b0;
         a_mag <= '0;  a_neg <= 1'b0;  b_mag <= '0;  dig_cnt <= '0;
         div_cnt <= '0;  div_rem <= '0;  div_q <= '0;
         disp_val <= '0;  disp_neg <= 1'b0;  err <= 1'b0;  busy <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= state_n;  op <= op_n;  calc_op <= calc_op_n;  to_result <= to_result_n;
         a_mag <= a_mag_n;  a_neg <= a_neg_n;  b_mag <= b_mag_n;  dig_cnt <= dig_cnt_n;
         div_cnt <= div_cnt_n;  div_rem <= div_rem_n;  div_q <= div_q_n;
         disp_val <= disp_val_n;  disp_neg <= disp_neg_n;
         err  <= (state_n == ERROR);
         busy <= (state_n == CALC);
      end
   end

endmodule

// File: tb/tb_calc_engine.sv
// Bench for calc_engine: directed key sequences plus random key streams, all checked
// every cycle against a behavioural calculator model held in plain integers.
module tb_calc_engine;

   localparam int     MAX_DIGITS = 8;
   localparam int     DATA_W     = 27;
   localparam longint MAXV       = 64'd99999999;
   localparam int     K_ADD = 10, K_SUB = 11, K_MUL = 12, K_DIV = 13, K_EQ = 14, K_CLR = 15;
   localparam int     M_A = 0, M_OPW = 1, M_B = 2, M_RES = 3, M_ERR = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [15:0]       key_pulse = '0;
   logic [DATA_W-1:0] disp_val;
   logic              disp_neg, err, busy;

   calc_engine #(.MAX_DIGITS(MAX_DIGITS), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse),
      .disp_val(disp_val), .disp_neg(disp_neg), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int     m_mode, m_op, m_cnt, m_busy_left;
   longint m_a, m_b, m_res;
   bit     m_res_err, m_res_final;
   longint e_val;
   bit     e_neg, e_err, e_busy;
   bit     chk_en = 1'b0;

   task automatic model_reset();
      m_mode = M_A;  m_op = 0;  m_cnt = 0;  m_busy_left = 0;
      m_a = 0;  m_b = 0;  m_res = 0;  m_res_err = 0;  m_res_final = 0;
      e_val = 0;  e_neg = 0;  e_err = 0;  e_busy = 0;
   endtask

   function automatic void enter_digit(inout longint v, inout int cnt, input int d);
      if (!(v == 0 && d == 0) && cnt < MAX_DIGITS) begin
         v = v * 10 + d;
         cnt++;
      end
   endfunction

   task automatic start_calc(input bit to_res);
      longint r;
      bit     bad;
      r = 0;  bad = 0;
      case (m_op)
         K_ADD:   r = m_a + m_b;
         K_SUB:   r = m_a - m_b;
         K_MUL:   r = m_a * m_b;
         default: if (m_b == 0) bad = 1; else r = m_a / m_b;
      endcase
      if (r > MAXV || r < -MAXV) bad = 1;
      m_busy_left = (m_op == K_DIV && m_b != 0) ? DATA_W + 1 : 1;
      m_res = r;  m_res_err = bad;  m_res_final = to_res;
   endtask

   task automatic model_key(input int idx);
      bit is_d, is_o, is_e;
      is_d = (idx <= 9);
      is_o = (idx >= K_ADD && idx <= K_DIV);
      is_e = (idx == K_EQ);
      case (m_mode)
         M_A:   if (is_d) enter_digit(m_a, m_cnt, idx);
                else if (is_o) begin m_op = idx;  m_mode = M_OPW; end
         M_OPW: if (is_d) begin m_b = idx;  m_cnt = 1;  m_mode = M_B; end
                else if (is_o) m_op = idx;
         M_B:   if (is_d) enter_digit(m_b, m_cnt, idx);
                else if (is_o || is_e) begin
                   start_calc(is_e);
                   if (is_o) m_op = idx;
                end
         M_RES: if (is_d) begin m_a = idx;  m_cnt = 1;  m_mode = M_A; end
                else if (is_o) begin m_op = idx;  m_mode = M_OPW; end
         default: ;
      endcase
   endtask

   task automatic model_step(input logic [15:0] k);
      int idx;
      idx = 0;
      for (int i = 0; i < 16; i++) if (k[i]) idx = i;
      if ($countones(k) == 1 && idx == K_CLR) begin
         model_reset();
      end else if (m_busy_left > 0) begin
         m_busy_left--;
         if (m_busy_left == 0) begin
            if (m_res_err) m_mode = M_ERR;
            else begin
               m_a = m_res;
               m_mode = m_res_final ? M_RES : M_OPW;
            end
         end
      end else if ($countones(k) == 1) begin
         model_key(idx);
      end
      if (m_busy_left > 0) begin
         e_busy = 1;  e_err = 0;
      end else begin
         e_busy = 0;
         e_err  = (m_mode == M_ERR);
         case (m_mode)
            M_B:     begin e_val = m_b;  e_neg = 0; end
            M_ERR:   begin e_val = 0;  e_neg = 0; end
            default: begin e_val = (m_a < 0) ? -m_a : m_a;  e_neg = (m_a < 0); end
         endcase
      end
   endtask

   // Compare process: outputs are sampled on the falling edge, away from the update edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_disp_val", disp_val, e_val);
         check("cyc_disp_neg", disp_neg, e_neg);
         check("cyc_err",      err,      e_err);
         check("cyc_busy",     busy,     e_busy);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle(input logic [15:0] k);
      @(negedge clk);
      key_pulse = k;
      @(posedge clk);
      #1;
      key_pulse = '0;
      model_step(k);
   endtask

   task automatic press(input int idx);
      cycle(16'd1 << idx);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle('0);
   endtask

   task automatic settle();
      int n;
      n = 0;
      while (busy && n < 64) begin cycle('0); n++; end
      if (busy) check("settle_timeout", 1, 0);
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy && n < 100) begin n++; cycle('0); end
   endtask

   function automatic int key_of(input byte c);
      case (c)
         "+":     return K_ADD;
         "-":     return K_SUB;
         "*":     return K_MUL;
         "/":     return K_DIV;
         "=":     return K_EQ;
         "C":     return K_CLR;
         default: return int'(c - "0");
      endcase
   endfunction

   task automatic seq(input string s);
      for (int i = 0; i < s.len(); i++) begin
         press(key_of(s[i]));
         idle(5);
         settle();
      end
   endtask

   task automatic expect_out(input string name, input longint val, input bit neg, input bit er);
      check({name, "_val"}, disp_val, val);
      check({name, "_neg"}, disp_neg, neg);
      check({name, "_err"}, err, er);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      logic [15:0] k;
      int r;

      model_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      expect_out("reset", 0, 0, 0);
      check("reset_busy", busy, 0);

      seq("12+34");
      check("entry_b", disp_val, 34);
      press(K_EQ);
      busy_len(n);
      check("busy_len_add", n, 1);
      expect_out("add_46", 46, 0, 0);

      seq("C7-9=");
      expect_out("sub_neg2", 2, 1, 0);
      seq("+5=");
      expect_out("chain_3", 3, 0, 0);

      seq("C100/7");
      press(K_EQ);
      busy_len(n);
      check("busy_len_div", n, DATA_W + 1);
      expect_out("div_14", 14, 0, 0);
      seq("C0-100=");
      expect_out("neg_100", 100, 1, 0);
      seq("/7=");
      expect_out("div_neg14", 14, 1, 0);

      seq("C2+3*");
      expect_out("chain_mid5", 5, 0, 0);
      seq("4=");
      expect_out("chain_20", 20, 0, 0);
      seq("C2+-1=");
      expect_out("op_replace", 1, 0, 0);

      seq("C5/0");
      press(K_EQ);
      busy_len(n);
      check("busy_len_div0", n, 1);
      expect_out("div0", 0, 0, 1);
      seq("7");
      expect_out("err_hold", 0, 0, 1);
      seq("C");
      expect_out("err_clear", 0, 0, 0);

      seq("C99999999+1=");
      expect_out("ovf", 0, 0, 1);

      seq("C123456789");
      expect_out("max_digits", 12345678, 0, 0);
      cycle(16'h0003);
      idle(2);
      expect_out("two_keys", 12345678, 0, 0);

      seq("C100/7");
      press(K_EQ);
      idle(3);
      press(5);
      settle();
      expect_out("busy_drop", 14, 0, 0);

      seq("C100/7");
      press(K_EQ);
      idle(5);
      press(K_CLR);
      expect_out("clr_mid_div", 0, 0, 0);
      check("clr_mid_div_busy", busy, 0);
      seq("3");
      expect_out("after_clr", 3, 0, 0);

      seq("C456");
      expect_out("pre_rst", 456, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      expect_out("async_rst", 0, 0, 0);
      check("async_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seq("8");
      expect_out("post_rst", 8, 0, 0);

      // Random key streams, including multi-bit strobes and keys during busy windows.
      seq("C");
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(99, 0));
         if (r < 55)      k = 16'd1 << $urandom_range(9, 0);
         else if (r < 75) k = 16'd1 << $urandom_range(13, 10);
         else if (r < 86) k = 16'd1 << K_EQ;
         else if (r < 91) k = 16'd1 << K_CLR;
         else if (r < 95) k = '0;
         else             k = 16'($urandom());
         cycle(k);
         idle(int'($urandom_range(2, 0)));
      end
      settle();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
